// File: rtl/arduino_link_pkg.sv
// Shared definitions for the Arduino serial link (status transmitter now,
// command receiver later).
//   tx_state_t            : transmitter frame FSM states
//   DEFAULT_CLKS_PER_BIT  : 50 MHz / 9600 baud
//   ACK_STOP/MODE_*       : status bytes understood by the Arduino side
package arduino_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    localparam logic [7:0] ACK_STOP    = 8'h58;
    localparam logic [7:0] MODE_MANUAL = 8'h4D;
    localparam logic [7:0] MODE_AUTO   = 8'h41;

endpackage

// File: rtl/arduino_status_tx_baud_counter.sv
// Bit-period timer for the Arduino serial link.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to 0 (used on every state entry)
//   enable     : advance the count
//   bit_done   : high on the last cycle of a bit period (count == CLKS_PER_BIT-1)
module baud_counter
    import arduino_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_param
        $error("baud_counter: CLKS_PER_BIT must be >= 2");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            // Wrap on terminal count so consecutive bits in one state
            // (DATA) need no explicit clear.
            cnt <= bit_done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/arduino_status_tx.sv
// UART transmitter for status/acknowledge bytes sent back to the Arduino.
// 8N1 framing, or 8E1 when PARITY_EN=1. A one-entry holding register lets
// the next byte be queued while a frame is on the wire, so back-to-back
// frames go out with no idle gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   tx_data    : byte to send
//   tx_valid   : tx_data is valid
//   tx_ready   : holding register free; transfer on tx_valid && tx_ready
//   tx         : registered serial line, idle high
//   busy       : a frame is in progress
module arduino_status_tx
    import arduino_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    tx_state_t  state, state_nxt;
    logic [7:0] hold;
    logic       hold_full;
    logic [7:0] shift;
    logic       par;
    logic [2:0] bit_idx;
    logic       bit_done;
    logic       load;
    logic       accept;
    logic       tx_nxt;

    assign tx_ready = !hold_full;
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && !hold_full;

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_nxt != state),
        .enable  (state != IDLE),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_done) state_nxt = DATA;
            end
            DATA: begin
                if (bit_done && bit_idx == 3'd7)
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_done) state_nxt = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    if (hold_full) begin
                        load      = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // tx is registered, so it is driven from the state being entered.
        // Inside DATA a bit boundary shifts the register, so the next bit
        // on the line is shift[1].
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = (state == DATA && bit_done) ? shift[1] : shift[0];
            PARITY:  tx_nxt = par;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx        <= 1'b1;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            par       <= 1'b0;
            bit_idx   <= '0;
        end else begin
            tx <= tx_nxt;

            // accept and load never coincide: accept needs !hold_full,
            // load needs hold_full.
            if (accept) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                shift <= hold;
                par   <= ^hold;
            end else if (state == DATA && bit_done) begin
                shift <= {1'b0, shift[7:1]};
            end

            if (state == START)
                bit_idx <= '0;
            else if (state == DATA && bit_done)
                bit_idx <= bit_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_arduino_status_tx.sv
module tb_arduino_status_tx;

    logic       clk;
    logic       rst_n;

    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       r0, r1, r2;
    logic       t0, t1, t2;
    logic       b0, b1, b2;

    int checks;
    int errors;

    // 8N1, 4 clocks per bit
    arduino_status_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0),
        .tx_ready(r0), .tx(t0), .busy(b0)
    );
    // 8E1, 4 clocks per bit
    arduino_status_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1),
        .tx_ready(r1), .tx(t1), .busy(b1)
    );
    // 8N1, real baud rate
    arduino_status_tx #(.CLKS_PER_BIT(5208), .PARITY_EN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2),
        .tx_ready(r2), .tx(t2), .busy(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (t0 !== 1'b1) begin errors++; $display("FAIL reset_tx0 got %b exp 1", t0); end
        checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b exp 1", r0); end
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b exp 0", b0); end
        checks++; if (t1 !== 1'b1 || r1 !== 1'b1 || b1 !== 1'b0) begin
            errors++; $display("FAIL reset_dut1 got tx=%b rdy=%b busy=%b exp 1 1 0", t1, r1, b1);
        end
        checks++; if (t2 !== 1'b1 || r2 !== 1'b1 || b2 !== 1'b0) begin
            errors++; $display("FAIL reset_dut2 got tx=%b rdy=%b busy=%b exp 1 1 0", t2, r2, b2);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (t0 !== 1'b1 || b0 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet bad_cycles %0d exp 0", bad); end
    endtask

    task automatic test_frame_8n1();
        logic [7:0] d;
        logic [9:0] fr;
        d = 8'h57;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = d[i];
        fr[9] = 1'b1;
        @(negedge clk);
        d0 = d; v0 = 1'b1;
        @(negedge clk);                  // after transfer edge k
        v0 = 1'b0; d0 = 8'hAA;           // later tx_data changes must not matter
        checks++; if (t0 !== 1'b1) begin errors++; $display("FAIL n1_latency tx got %b exp 1", t0); end
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL n1_ready_held got %b exp 0", r0); end
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            checks++;
            if (t0 !== fr[(t-1)/4] || b0 !== 1'b1) begin
                errors++;
                $display("FAIL n1_frame cyc %0d got tx=%b busy=%b exp tx=%b busy=1", t, t0, b0, fr[(t-1)/4]);
            end
        end
        @(negedge clk);
        checks++; if (t0 !== 1'b1 || b0 !== 1'b0 || r0 !== 1'b1) begin
            errors++; $display("FAIL n1_end got tx=%b busy=%b rdy=%b exp 1 0 1", t0, b0, r0);
        end
    endtask

    task automatic test_frame_8e1();
        logic [7:0]  d;
        logic [10:0] fr;
        d = 8'h57;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = d[i];
        fr[9]  = ^d;                     // popcount 5 -> 1
        fr[10] = 1'b1;
        @(negedge clk);
        d1 = d; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        checks++; if (t1 !== 1'b1 || b1 !== 1'b0) begin
            errors++; $display("FAIL e1_latency got tx=%b busy=%b exp 1 0", t1, b1);
        end
        for (int t = 1; t <= 44; t++) begin
            @(negedge clk);
            checks++;
            if (t1 !== fr[(t-1)/4] || b1 !== 1'b1) begin
                errors++;
                $display("FAIL e1_frame cyc %0d got tx=%b busy=%b exp tx=%b busy=1", t, t1, b1, fr[(t-1)/4]);
            end
        end
        @(negedge clk);
        checks++; if (t1 !== 1'b1 || b1 !== 1'b0) begin
            errors++; $display("FAIL e1_end got tx=%b busy=%b exp 1 0", t1, b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [9:0] fr [3];
        logic       exp_tx, exp_rdy, exp_busy;
        int         f, w;
        bytes[0] = 8'h4D; bytes[1] = 8'h41; bytes[2] = 8'h58;
        for (int k = 0; k < 3; k++) begin
            fr[k][0] = 1'b0;
            for (int i = 0; i < 8; i++) fr[k][i+1] = bytes[k][i];
            fr[k][9] = 1'b1;
        end
        @(negedge clk);
        d0 = bytes[0]; v0 = 1'b1;
        @(negedge clk);                  // after edge k: 0x4D held
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL b2b_ready_t0 got %b exp 0", r0); end
        d0 = bytes[1];                   // tx_valid stays high
        for (int t = 1; t <= 125; t++) begin
            @(negedge clk);
            f = (t - 1) / 40;
            w = ((t - 1) % 40) / 4;
            exp_tx   = (f < 3) ? fr[f][w] : 1'b1;
            exp_busy = (t <= 120);
            // ready: free after first load, refilled at t=2, free again
            // at the second frame start, refilled at t=42, free after the
            // third frame start.
            exp_rdy  = (t == 1) || (t == 41) || (t >= 81);
            checks++;
            if (t0 !== exp_tx || b0 !== exp_busy || r0 !== exp_rdy) begin
                errors++;
                $display("FAIL b2b cyc %0d got tx=%b busy=%b rdy=%b exp tx=%b busy=%b rdy=%b",
                         t, t0, b0, r0, exp_tx, exp_busy, exp_rdy);
            end
            if (t == 2)  d0 = bytes[2];
            if (t == 42) v0 = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        @(negedge clk);
        d0 = 8'hFF; v0 = 1'b1;
        @(negedge clk);                  // t=0
        d0 = 8'h00;                      // queue a second byte once ready
        @(negedge clk);                  // t=1, 0xFF loaded, ready again
        @(negedge clk);                  // t=2, 0x00 accepted
        v0 = 1'b0;
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL mid_hold_full rdy got %b exp 0", r0); end
        repeat (8) @(negedge clk);       // t=10, inside DATA
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", b0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (t0 !== 1'b1 || b0 !== 1'b0 || r0 !== 1'b1) begin
            errors++; $display("FAIL mid_async_reset got tx=%b busy=%b rdy=%b exp 1 0 1", t0, b0, r0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (t0 !== 1'b1 || b0 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_residual bad_cycles %0d exp 0", bad); end
    endtask

    task automatic test_real_baud();
        int lows, first_bad;
        logic exp_tx, exp_busy;
        @(negedge clk);
        d2 = 8'h00; v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        lows = 0; first_bad = 0;
        for (int t = 1; t <= 52081; t++) begin
            @(negedge clk);
            exp_tx   = (t > 46872);
            exp_busy = (t <= 52080);
            if (t0 === 1'b0 && t2 === 1'b0) lows = lows; // keep dut0 untouched
            if (t2 === 1'b0) lows++;
            if ((t2 !== exp_tx || b2 !== exp_busy) && first_bad == 0) first_bad = t;
        end
        checks++; if (lows != 46872) begin errors++; $display("FAIL baud_low_len got %0d exp 46872", lows); end
        checks++; if (first_bad != 0) begin
            errors++; $display("FAIL baud_wave first bad cycle %0d exp 0", first_bad);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        test_reset();
        test_frame_8n1();
        test_frame_8e1();
        test_back_to_back();
        test_reset_mid_frame();
        test_real_baud();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
